// File: rtl/seg7_seq_checker_pkg.sv
// rtl/seg7_seq_checker_pkg.sv - shared state encodings and 7-segment code constants
package seg7_seq_checker_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_ACQ    = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    // Active-low segment codes, bit0=a ... bit5=f, bit6=g
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    localparam logic [3:0] DIGIT_ILLEGAL = 4'hF;

    function automatic logic [3:0] next_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : 4'(d + 4'd1);
    endfunction

endpackage

// File: rtl/seg7_seq_checker_decode.sv
// rtl/seg7_seq_checker_decode.sv - combinational active-low 7-segment to BCD decoder
module seg7_decode
    import seg7_seq_checker_pkg::*;
(
    input  logic [6:0] seg_in,
    output logic       legal,
    output logic [3:0] digit
);

    always_comb begin
        legal = 1'b1;
        digit = DIGIT_ILLEGAL;
        case (seg_in)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_seq_checker.sv
// rtl/seg7_seq_checker.sv - 7-segment up-count sequence monitor with lock FSM and error counter
module seg7_seq_checker
    import seg7_seq_checker_pkg::*;
#(
    parameter int LOCK_N = 3,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg_in,
    input  logic             seg_valid,
    input  logic             err_clr,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             code_err,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0]       LOCK_RUN = 4'(LOCK_N);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_t     state, state_nxt;
    logic [3:0] run, run_nxt, run_inc;
    logic [3:0] digit_nxt;
    logic       dv_nxt, ce_nxt, se_nxt;
    logic       dec_legal;
    logic [3:0] dec_digit;
    logic       match;

    seg7_decode u_decode (
        .seg_in (seg_in),
        .legal  (dec_legal),
        .digit  (dec_digit)
    );

    // digit always holds the last legal symbol, so it doubles as the reference
    assign match   = (dec_digit == next_digit(digit));
    assign run_inc = 4'(run + 4'd1);

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        digit_nxt = digit;
        dv_nxt    = 1'b0;
        ce_nxt    = 1'b0;
        se_nxt    = 1'b0;
        if (seg_valid) begin
            if (!dec_legal) begin
                ce_nxt    = 1'b1;
                state_nxt = ST_HUNT;
                run_nxt   = 4'd0;
            end else begin
                dv_nxt    = 1'b1;
                digit_nxt = dec_digit;
                case (state)
                    ST_HUNT: begin
                        run_nxt   = 4'd1;
                        state_nxt = (LOCK_RUN == 4'd1) ? ST_LOCKED : ST_ACQ;
                    end
                    ST_ACQ: begin
                        if (match) begin
                            run_nxt = run_inc;
                            if (run_inc >= LOCK_RUN) state_nxt = ST_LOCKED;
                        end else begin
                            run_nxt = 4'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!match) begin
                            se_nxt    = 1'b1;
                            run_nxt   = 4'd1;
                            state_nxt = ST_ACQ;
                        end
                    end
                    default: begin
                        state_nxt = ST_HUNT;
                        run_nxt   = 4'd0;
                    end
                endcase
            end
        end
        if (!(state inside {ST_HUNT, ST_ACQ, ST_LOCKED})) begin
            state_nxt = ST_HUNT;
            run_nxt   = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_HUNT;
            run         <= 4'd0;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            code_err    <= 1'b0;
            seq_err     <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_nxt;
            run         <= run_nxt;
            digit       <= digit_nxt;
            digit_valid <= dv_nxt;
            code_err    <= ce_nxt;
            seq_err     <= se_nxt;
            locked      <= (state_nxt == ST_LOCKED);
        end
    end

    // Clear wins over the old count but not over an event arriving the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= (ce_nxt || se_nxt) ? ERR_W'(1) : '0;
        end else if ((ce_nxt || se_nxt) && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_seg7_seq_checker.sv
// tb/tb_seg7_seq_checker.sv - directed self-checking bench for seg7_seq_checker
module tb_seg7_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_in = 7'h7F;
    logic       seg_valid = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] digit;
    logic       digit_valid, code_err, seq_err, locked;
    logic [1:0] err_count;

    int total = 0;
    int bad   = 0;

    logic [6:0] code [10];
    localparam logic [6:0] ILL = 7'b1111111;

    seg7_seq_checker #(.LOCK_N(3), .ERR_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .seg_valid   (seg_valid),
        .err_clr     (err_clr),
        .digit       (digit),
        .digit_valid (digit_valid),
        .code_err    (code_err),
        .seq_err     (seq_err),
        .locked      (locked),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ex(input logic [3:0] d, input logic dv, input logic ce,
                                      input logic se, input logic lk, input logic [1:0] ec);
        return {d, dv, ce, se, lk, ec};
    endfunction

    task automatic chk(input string tag, input logic [9:0] expv);
        logic [9:0] obs;
        obs = {digit, digit_valid, code_err, seq_err, locked, err_count};
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s obs={d%h dv%b ce%b se%b lk%b ec%0d} exp={d%h dv%b ce%b se%b lk%b ec%0d}",
                   tag, obs[9:6], obs[5], obs[4], obs[3], obs[2], obs[1:0],
                   expv[9:6], expv[5], expv[4], expv[3], expv[2], expv[1:0]);
        end
    endtask

    task automatic step(input logic [6:0] s, input logic v, input logic c);
        @(negedge clk);
        seg_in    = s;
        seg_valid = v;
        err_clr   = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        code[0] = 7'b1000000; code[1] = 7'b1111001; code[2] = 7'b0100100;
        code[3] = 7'b0110000; code[4] = 7'b0011001; code[5] = 7'b0010010;
        code[6] = 7'b0000010; code[7] = 7'b1111000; code[8] = 7'b0000000;
        code[9] = 7'b0010000;

        repeat (2) @(posedge clk);
        #1;
        chk("reset", ex(4'd0, 0, 0, 0, 0, 2'd0));
        @(negedge clk);
        rst = 1'b0;

        // 0..9,0,1 back to back: lock after third symbol, clean 9->0 wrap
        for (int i = 0; i < 12; i++) begin
            step(code[i % 10], 1'b1, 1'b0);
            chk($sformatf("count_%0d", i), ex(4'(i % 10), 1, 0, 0, (i >= 2), 2'd0));
        end
        for (int i = 2; i <= 5; i++) begin
            step(code[i], 1'b1, 1'b0);
            chk($sformatf("run_to5_%0d", i), ex(4'(i), 1, 0, 0, 1, 2'd0));
        end

        // Break while locked: 7 after 5; 7 restarts the run, so 7,8,9 relocks on 9
        step(code[7], 1'b1, 1'b0);
        chk("seq_break", ex(4'd7, 1, 0, 1, 0, 2'd1));
        step(code[8], 1'b1, 1'b0);
        chk("reacq_8", ex(4'd8, 1, 0, 0, 0, 2'd1));
        step(code[9], 1'b1, 1'b0);
        chk("reacq_9", ex(4'd9, 1, 0, 0, 1, 2'd1));
        step(code[0], 1'b1, 1'b0);
        chk("reacq_0", ex(4'd0, 1, 0, 0, 1, 2'd1));

        // Illegal code while locked: digit holds, back to HUNT
        step(ILL, 1'b1, 1'b0);
        chk("illegal_locked", ex(4'd0, 0, 1, 0, 0, 2'd2));
        step(code[5], 1'b1, 1'b0);
        chk("hunt_5", ex(4'd5, 1, 0, 0, 0, 2'd2));
        step(code[6], 1'b1, 1'b0);
        chk("acq_6", ex(4'd6, 1, 0, 0, 0, 2'd2));
        step(code[7], 1'b1, 1'b0);
        chk("lock_7", ex(4'd7, 1, 0, 0, 1, 2'd2));

        // Error counter clear and saturation
        step(ILL, 1'b0, 1'b1);
        chk("clr_alone", ex(4'd7, 0, 0, 0, 1, 2'd0));
        for (int i = 1; i <= 5; i++) begin
            step(7'b1010101, 1'b1, 1'b0);
            chk($sformatf("sat_%0d", i), ex(4'd7, 0, 1, 0, 0, 2'(i > 3 ? 3 : i)));
        end
        step(ILL, 1'b0, 1'b1);
        chk("clr_after_sat", ex(4'd7, 0, 0, 0, 0, 2'd0));
        step(ILL, 1'b1, 1'b1);
        chk("clr_with_err", ex(4'd7, 0, 1, 0, 0, 2'd1));

        // Gapped valid with garbage on the bus during idle cycles
        step(code[3], 1'b1, 1'b0);
        chk("gap_3", ex(4'd3, 1, 0, 0, 0, 2'd1));
        step(ILL, 1'b0, 1'b0);
        chk("gap_idle_a", ex(4'd3, 0, 0, 0, 0, 2'd1));
        step(code[4], 1'b1, 1'b0);
        chk("gap_4", ex(4'd4, 1, 0, 0, 0, 2'd1));
        step(7'b0101010, 1'b0, 1'b0);
        chk("gap_idle_b", ex(4'd4, 0, 0, 0, 0, 2'd1));
        step(code[5], 1'b1, 1'b0);
        chk("gap_5", ex(4'd5, 1, 0, 0, 1, 2'd1));

        // Asynchronous reset mid-stream, away from any clock edge
        seg_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst", ex(4'd0, 0, 0, 0, 0, 2'd0));
        @(negedge clk);
        rst = 1'b0;
        step(code[4], 1'b1, 1'b0);
        chk("post_rst_4", ex(4'd4, 1, 0, 0, 0, 2'd0));
        step(code[5], 1'b1, 1'b0);
        chk("post_rst_5", ex(4'd5, 1, 0, 0, 0, 2'd0));
        step(code[6], 1'b1, 1'b0);
        chk("post_rst_6", ex(4'd6, 1, 0, 0, 1, 2'd0));
        step(code[6], 1'b0, 1'b0);
        chk("post_rst_idle", ex(4'd6, 0, 0, 0, 1, 2'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
